// File: rtl/wb_burst_adapter.sv
// Burst-to-single-beat Wishbone adapter: splits each upstream burst into single
// peripheral accesses and returns a per-beat ack, plus lack on the last beat.
module wb_burst_adapter #(
  parameter int          TO_W    = 8,
  parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s_wbd_dat_i,
  input  logic [31:0] s_wbd_adr_i,
  input  logic [3:0]  s_wbd_sel_i,
  input  logic [9:0]  s_wbd_bl_i,
  input  logic        s_wbd_bry_i,
  input  logic        s_wbd_we_i,
  input  logic        s_wbd_cyc_i,
  input  logic        s_wbd_stb_i,
  output logic [31:0] s_wbd_dat_o,
  output logic        s_wbd_ack_o,
  output logic        s_wbd_lack_o,
  output logic [31:0] p_wbd_adr_o,
  output logic [31:0] p_wbd_dat_o,
  output logic [3:0]  p_wbd_sel_o,
  output logic        p_wbd_we_o,
  output logic        p_wbd_cyc_o,
  output logic        p_wbd_stb_o,
  input  logic [31:0] p_wbd_dat_i,
  input  logic        p_wbd_ack_i
);

  typedef enum logic [1:0] {IDLE, BEAT, GAP, DONE} state_t;

  state_t          state, state_nxt;
  logic [29:0]     cur, cur_nxt;
  logic [9:0]      rem, rem_nxt;
  logic [TO_W-1:0] wd, wd_nxt;
  logic [31:0]     s_dat_nxt, p_adr_nxt, p_dat_nxt;
  logic [3:0]      p_sel_nxt;
  logic            s_ack_nxt, s_lack_nxt, p_we_nxt, p_cyc_nxt, p_stb_nxt;
  logic            timeout, beat_end;
  logic            unused;

  assign unused   = ^s_wbd_adr_i[1:0];
  assign timeout  = (wd == {TO_W{1'b1}});
  assign beat_end = p_wbd_ack_i || timeout;

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    rem_nxt    = rem;
    wd_nxt     = wd;
    s_dat_nxt  = '0;
    s_ack_nxt  = 1'b0;
    s_lack_nxt = 1'b0;
    p_adr_nxt  = p_wbd_adr_o;
    p_dat_nxt  = p_wbd_dat_o;
    p_sel_nxt  = p_wbd_sel_o;
    p_we_nxt   = p_wbd_we_o;
    p_cyc_nxt  = p_wbd_cyc_o;
    p_stb_nxt  = p_wbd_stb_o;
    case (state)
      IDLE: begin
        if (s_wbd_cyc_i && s_wbd_stb_i) begin
          cur_nxt   = s_wbd_adr_i[31:2];
          rem_nxt   = (s_wbd_bl_i == 10'd0) ? 10'd1 : s_wbd_bl_i;
          p_adr_nxt = {s_wbd_adr_i[31:2], 2'b00};
          p_sel_nxt = s_wbd_sel_i;
          p_we_nxt  = s_wbd_we_i;
          p_cyc_nxt = 1'b1;
          if (s_wbd_bry_i) begin
            state_nxt = BEAT;
            p_stb_nxt = 1'b1;
            p_dat_nxt = s_wbd_dat_i;
            wd_nxt    = '0;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      BEAT: begin
        if (!s_wbd_cyc_i) begin
          state_nxt = IDLE;
          p_cyc_nxt = 1'b0;
          p_stb_nxt = 1'b0;
        end else begin
          p_dat_nxt = s_wbd_dat_i;
          wd_nxt    = wd + 1'b1;
          if (beat_end) begin
            p_stb_nxt = 1'b0;
            s_ack_nxt = 1'b1;
            // A real ack wins over a simultaneous watchdog expiry.
            s_dat_nxt = p_wbd_we_o ? 32'd0 : (p_wbd_ack_i ? p_wbd_dat_i : TO_DATA);
            if (rem == 10'd1) begin
              s_lack_nxt = 1'b1;
              p_cyc_nxt  = 1'b0;
              state_nxt  = DONE;
            end else begin
              rem_nxt   = rem - 10'd1;
              cur_nxt   = cur + 30'd1;
              p_adr_nxt = {cur_nxt, 2'b00};
              state_nxt = GAP;
            end
          end
        end
      end
      GAP: begin
        if (!s_wbd_cyc_i) begin
          state_nxt = IDLE;
          p_cyc_nxt = 1'b0;
          p_stb_nxt = 1'b0;
        // bry seen during the ack cycle still belongs to the previous beat.
        end else if (s_wbd_bry_i && !s_wbd_ack_o) begin
          state_nxt = BEAT;
          p_stb_nxt = 1'b1;
          p_dat_nxt = s_wbd_dat_i;
          wd_nxt    = '0;
        end
      end
      DONE: begin
        if (!s_wbd_stb_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      s_wbd_dat_o  <= '0;
      s_wbd_ack_o  <= 1'b0;
      s_wbd_lack_o <= 1'b0;
      p_wbd_adr_o  <= '0;
      p_wbd_dat_o  <= '0;
      p_wbd_sel_o  <= '0;
      p_wbd_we_o   <= 1'b0;
      p_wbd_cyc_o  <= 1'b0;
      p_wbd_stb_o  <= 1'b0;
    end else begin
      state        <= state_nxt;
      s_wbd_dat_o  <= s_dat_nxt;
      s_wbd_ack_o  <= s_ack_nxt;
      s_wbd_lack_o <= s_lack_nxt;
      p_wbd_adr_o  <= p_adr_nxt;
      p_wbd_dat_o  <= p_dat_nxt;
      p_wbd_sel_o  <= p_sel_nxt;
      p_wbd_we_o   <= p_we_nxt;
      p_wbd_cyc_o  <= p_cyc_nxt;
      p_wbd_stb_o  <= p_stb_nxt;
    end
  end

  // Burst bookkeeping is always reloaded on accept, so it needs no reset.
  always_ff @(posedge clk_i) begin
    cur <= cur_nxt;
    rem <= rem_nxt;
    wd  <= wd_nxt;
  end

endmodule

// File: tb/tb_wb_burst_adapter.sv
// Directed bench for wb_burst_adapter with a simple peripheral responder
// (configurable ack delay, read data = address ^ 0xFFFF).
module tb_wb_burst_adapter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_dat_i = '0, s_adr = '0;
  logic [3:0]  s_sel = '0;
  logic [9:0]  s_bl = '0;
  logic        s_bry = 1'b1, s_we = 1'b0, s_cyc = 1'b0, s_stb = 1'b0;
  logic [31:0] s_dat_o, p_adr, p_dat_o;
  logic        s_ack, s_lack, p_we, p_cyc, p_stb;
  logic [3:0]  p_sel;
  logic [31:0] p_dat_i = '0;
  logic        p_ack = 1'b0;

  int tests = 0, fails = 0;
  int ack_dly = 0, stb_cnt = 0, cycle = 0, lack_cnt = 0;
  logic prev_stb = 1'b0;
  logic [31:0] beat_adr[$], beat_dat[$], ack_dat[$];
  logic        beat_we[$], ack_lack[$];
  int          stb_cyc[$], ack_cyc[$];

  always #5 clk = ~clk;

  wb_burst_adapter #(.TO_W(4), .TO_DATA(32'hFFFF_FFFF)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_wbd_dat_i(s_dat_i), .s_wbd_adr_i(s_adr), .s_wbd_sel_i(s_sel), .s_wbd_bl_i(s_bl),
    .s_wbd_bry_i(s_bry), .s_wbd_we_i(s_we), .s_wbd_cyc_i(s_cyc), .s_wbd_stb_i(s_stb),
    .s_wbd_dat_o(s_dat_o), .s_wbd_ack_o(s_ack), .s_wbd_lack_o(s_lack),
    .p_wbd_adr_o(p_adr), .p_wbd_dat_o(p_dat_o), .p_wbd_sel_o(p_sel), .p_wbd_we_o(p_we),
    .p_wbd_cyc_o(p_cyc), .p_wbd_stb_o(p_stb), .p_wbd_dat_i(p_dat_i), .p_wbd_ack_i(p_ack)
  );

  // Monitor and peripheral responder, evaluated away from the active edge.
  always @(negedge clk) begin
    cycle++;
    if (p_stb && !prev_stb) begin
      beat_adr.push_back(p_adr); beat_dat.push_back(p_dat_o);
      beat_we.push_back(p_we);   stb_cyc.push_back(cycle);
    end
    if (s_ack) begin
      ack_dat.push_back(s_dat_o); ack_lack.push_back(s_lack); ack_cyc.push_back(cycle);
    end
    if (s_lack) lack_cnt++;
    prev_stb = p_stb;
    stb_cnt  = p_stb ? stb_cnt + 1 : 0;
    p_ack    = p_stb && (ack_dly >= 0) && (stb_cnt == ack_dly + 1);
    p_dat_i  = p_adr ^ 32'h0000_FFFF;
  end

  task automatic clear_mon();
    beat_adr.delete(); beat_dat.delete(); beat_we.delete(); stb_cyc.delete();
    ack_dat.delete(); ack_lack.delete(); ack_cyc.delete();
    lack_cnt = 0;
  endtask

  task automatic start_burst(input logic [31:0] adr, input logic [9:0] bl,
                             input logic we, input logic [31:0] dat);
    @(negedge clk); #1;
    clear_mon();
    s_adr = adr; s_bl = bl; s_we = we; s_sel = 4'hF; s_dat_i = dat;
    s_bry = 1'b1; s_cyc = 1'b1; s_stb = 1'b1;
  endtask

  task automatic end_burst();
    @(negedge clk); #1;
    s_cyc = 1'b0; s_stb = 1'b0; s_bry = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_acks(input int n, input int bound, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (ack_dat.size() >= n) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: ack count %0d, required %0d", name, ack_dat.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({s_ack, s_lack, p_we, p_cyc, p_stb, p_sel} !== 9'd0) begin
      fails++; $display("FAIL reset_ctrl: got %h, required 0", {s_ack, s_lack, p_we, p_cyc, p_stb, p_sel});
    end
    tests++;
    if ({p_adr, p_dat_o, s_dat_o} !== 96'd0) begin
      fails++; $display("FAIL reset_data: got %h, required 0", {p_adr, p_dat_o, s_dat_o});
    end
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    ack_dly = 2;
    start_burst(32'h104, 10'd1, 1'b1, 32'hA5A5_0001);
    wait_acks(1, 40, "write_ack");
    repeat (5) @(negedge clk); // strobe still held: must not retrigger
    #1;
    tests++;
    if (beat_adr.size() !== 1) begin fails++; $display("FAIL write_beats: got %0d, required 1", beat_adr.size()); end
    tests++;
    if (beat_adr[0] !== 32'h104 || beat_dat[0] !== 32'hA5A5_0001 || beat_we[0] !== 1'b1) begin
      fails++; $display("FAIL write_beat: adr %h dat %h we %b, required 104 a5a50001 1", beat_adr[0], beat_dat[0], beat_we[0]);
    end
    tests++;
    if (ack_dat.size() !== 1 || ack_lack[0] !== 1'b1 || lack_cnt !== 1) begin
      fails++; $display("FAIL write_ack_lack: acks %0d lack %b lacks %0d, required 1 1 1", ack_dat.size(), ack_lack[0], lack_cnt);
    end
    tests++;
    if (ack_dat[0] !== 32'd0) begin fails++; $display("FAIL write_sdat: got %h, required 0", ack_dat[0]); end
    tests++;
    if (p_cyc !== 1'b0) begin fails++; $display("FAIL write_done_cyc: got %b, required 0", p_cyc); end
    end_burst();
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_dat [4] = '{32'hFDFF, 32'hFDFB, 32'hFDF7, 32'hFDF3};
    ack_dly = 0;
    start_burst(32'h200, 10'd4, 1'b0, 32'h0);
    wait_acks(4, 80, "read_acks");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (beat_adr[i] !== 32'h200 + 32'(4 * i)) begin
        fails++; $display("FAIL read_adr%0d: got %h, required %h", i, beat_adr[i], 32'h200 + 32'(4 * i));
      end
      tests++;
      if (ack_dat[i] !== exp_dat[i] || ack_lack[i] !== (i == 3)) begin
        fails++; $display("FAIL read_ack%0d: dat %h lack %b, required %h %b", i, ack_dat[i], ack_lack[i], exp_dat[i], (i == 3));
      end
    end
    tests++;
    if (lack_cnt !== 1 || ack_dat.size() !== 4) begin
      fails++; $display("FAIL read_counts: lacks %0d acks %0d, required 1 4", lack_cnt, ack_dat.size());
    end
    end_burst();
  endtask

  task automatic test_backpressure();
    int c_raise;
    bit held_ok = 1'b1;
    ack_dly = 0;
    start_burst(32'h400, 10'd3, 1'b0, 32'h0);
    @(negedge clk); #1;
    s_bry = 1'b0;
    wait_acks(1, 20, "bp_first_ack");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (p_stb !== 1'b0 || p_cyc !== 1'b1) held_ok = 1'b0;
    end
    tests++;
    if (!held_ok || beat_adr.size() !== 1) begin
      fails++; $display("FAIL bp_hold: stb %b cyc %b beats %0d, required 0 1 1", p_stb, p_cyc, beat_adr.size());
    end
    c_raise = cycle;
    s_bry = 1'b1;
    wait_acks(3, 40, "bp_acks");
    tests++;
    if (stb_cyc[1] !== c_raise + 1 || beat_adr[1] !== 32'h404) begin
      fails++; $display("FAIL bp_resume: cycle %0d adr %h, required %0d 404", stb_cyc[1], beat_adr[1], c_raise + 1);
    end
    tests++;
    if (ack_lack[2] !== 1'b1 || lack_cnt !== 1) begin
      fails++; $display("FAIL bp_lack: lack %b lacks %0d, required 1 1", ack_lack[2], lack_cnt);
    end
    end_burst();
  endtask

  task automatic test_timeout();
    ack_dly = -1;
    start_burst(32'h300, 10'd2, 1'b0, 32'h0);
    wait_acks(2, 100, "to_acks");
    tests++;
    if (ack_cyc[0] - stb_cyc[0] !== 16 || ack_dat[0] !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL to_first: delay %0d dat %h, required 16 ffffffff", ack_cyc[0] - stb_cyc[0], ack_dat[0]);
    end
    tests++;
    if (beat_adr[1] !== 32'h304 || ack_dat[1] !== 32'hFFFF_FFFF || ack_lack[1] !== 1'b1) begin
      fails++; $display("FAIL to_second: adr %h dat %h lack %b, required 304 ffffffff 1", beat_adr[1], ack_dat[1], ack_lack[1]);
    end
    end_burst();
    // Peripheral acks in the very cycle the watchdog expires: real data wins.
    ack_dly = 15;
    start_burst(32'h500, 10'd1, 1'b0, 32'h0);
    wait_acks(1, 40, "tie_ack");
    tests++;
    if (ack_cyc[0] - stb_cyc[0] !== 16 || ack_dat[0] !== 32'h0000_FAFF) begin
      fails++; $display("FAIL to_tie: delay %0d dat %h, required 16 0000faff", ack_cyc[0] - stb_cyc[0], ack_dat[0]);
    end
    end_burst();
  endtask

  task automatic test_abort_reset();
    bit seen = 1'b0;
    ack_dly = 0;
    start_burst(32'h600, 10'd8, 1'b0, 32'h0);
    wait_acks(2, 40, "abort_acks");
    s_cyc = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (beat_adr.size() !== 2 || ack_dat.size() !== 2 || lack_cnt !== 0 || p_cyc !== 1'b0) begin
      fails++; $display("FAIL abort: beats %0d acks %0d lacks %0d cyc %b, required 2 2 0 0",
                        beat_adr.size(), ack_dat.size(), lack_cnt, p_cyc);
    end
    end_burst();
    ack_dly = -1;
    start_burst(32'h700, 10'd8, 1'b0, 32'h1234);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (p_stb) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL rst_beat_start: stb %b, required 1", p_stb); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({s_dat_o, s_ack, s_lack, p_adr, p_dat_o, p_sel, p_we, p_cyc, p_stb} !== 105'd0) begin
      fails++; $display("FAIL rst_mid: adr %h dat %h cyc %b stb %b ack %b, required all 0", p_adr, p_dat_o, p_cyc, p_stb, s_ack);
    end
    #1 rst = 1'b0;
    end_burst();
  endtask

  task automatic test_edges();
    ack_dly = 0;
    start_burst(32'h800, 10'd0, 1'b0, 32'h0);
    wait_acks(1, 20, "bl0_ack");
    repeat (4) @(negedge clk);
    tests++;
    if (beat_adr.size() !== 1 || ack_lack[0] !== 1'b1 || ack_dat[0] !== 32'h0000_F7FF) begin
      fails++; $display("FAIL bl0: beats %0d lack %b dat %h, required 1 1 0000f7ff", beat_adr.size(), ack_lack[0], ack_dat[0]);
    end
    end_burst();
    start_burst(32'hFFFF_FFFE, 10'd2, 1'b0, 32'h0);
    wait_acks(2, 30, "wrap_acks");
    tests++;
    if (beat_adr[0] !== 32'hFFFF_FFFC || beat_adr[1] !== 32'h0) begin
      fails++; $display("FAIL wrap_adr: got %h %h, required fffffffc 00000000", beat_adr[0], beat_adr[1]);
    end
    tests++;
    if (ack_dat[1] !== 32'h0000_FFFF || ack_lack[1] !== 1'b1 || ack_lack[0] !== 1'b0) begin
      fails++; $display("FAIL wrap_ack: dat %h lack %b%b, required 0000ffff 01", ack_dat[1], ack_lack[0], ack_lack[1]);
    end
    end_burst();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_backpressure();
    test_timeout();
    test_abort_reset();
    test_edges();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
